// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a selected code word out MSB-first on sout,
// optionally repeating it with idle-low gaps; drives the detector FSMs' w input.
module pattern_tx #(
  parameter int WORD_W     = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        sel,
  input  logic [WORD_W-1:0] data_in,
  input  logic [CNT_W-1:0]  reps,
  input  logic              abort,
  output logic              sout,
  output logic              bit_valid,
  output logic              busy,
  output logic              done,
  output logic [3:0]        state
);

  // Handshake: start is taken only in IDLE; busy stays high for the whole
  // transmission (SEND and GAP); done pulses one cycle afterwards unless aborted.
  localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WORD_W - 1);
  localparam logic [GC_W-1:0] GAP_LOAD = GC_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    SEND = 4'd1,
    GAP  = 4'd2,
    DONE = 4'd3
  } state_t;

  state_t            state_q;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] word_q;
  logic [BC_W-1:0]   bit_q;
  logic [CNT_W-1:0]  rep_q;
  logic [GC_W-1:0]   gap_q;
  logic [WORD_W-1:0] sel_word;
  logic              in_tx;

  always_comb begin
    sel_word = '0;
    case (sel)
      2'b00:   sel_word = {WORD_W{1'b1}};
      2'b01:   sel_word = WORD_W'(4'b1101);
      2'b10:   sel_word = data_in;
      default: sel_word = ~data_in;
    endcase
  end

  assign in_tx = (state_q == SEND) || (state_q == GAP);

  always_ff @(posedge clock) begin
    if (!resetn || (in_tx && abort)) begin
      state_q <= IDLE;
      shift_q <= '0;
      word_q  <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q <= sel_word;
            word_q  <= sel_word;
            bit_q   <= BIT_LAST;
            rep_q   <= reps;
            state_q <= SEND;
          end
        end
        SEND: begin
          shift_q <= shift_q << 1;
          bit_q   <= bit_q - 1'b1;
          if (bit_q == '0) begin
            if (rep_q == '0) begin
              bit_q   <= '0;
              state_q <= DONE;
            end else if (GAP_CYCLES > 0) begin
              gap_q   <= GAP_LOAD;
              state_q <= GAP;
            end else begin
              // Back-to-back repeat: reload the unshifted copy immediately.
              shift_q <= word_q;
              bit_q   <= BIT_LAST;
              rep_q   <= rep_q - 1'b1;
            end
          end
        end
        GAP: begin
          gap_q <= gap_q - 1'b1;
          if (gap_q == '0) begin
            shift_q <= word_q;
            bit_q   <= BIT_LAST;
            rep_q   <= rep_q - 1'b1;
            state_q <= SEND;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sout      = (state_q == SEND) && shift_q[WORD_W-1];
  assign bit_valid = (state_q == SEND);
  assign busy      = in_tx;
  assign done      = (state_q == DONE);
  assign state     = state_q;

endmodule
